// File: rtl/seg_decode_monitor.sv
// Read-back checker for a three-digit BCD 7-segment display: decodes the glyphs,
// tracks the hold/increment sequence and counts errors. Define SEG_ACTIVE_LOW_EN for common-anode buses.
module seg_decode_monitor #(
    parameter int LOCK_COUNT = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [6:0]           i_seg0,
    input  logic [6:0]           i_seg1,
    input  logic [6:0]           i_seg2,
    input  logic                 i_sample_en,
    output logic [11:0]          o_bcd,
    output logic [9:0]           o_value,
    output logic                 o_valid,
    output logic                 o_locked,
    output logic                 o_glyph_err,
    output logic                 o_seq_err,
    output logic [ERR_CNT_W-1:0] o_err_count
);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [3:0] LOCK_CNT_L = 4'(LOCK_COUNT);

    // Returns {legal, digit}; an unknown pattern yields legal=0.
    function automatic logic [4:0] decode_glyph(input logic [6:0] g);
        case (g)
            7'b1111110: return {1'b1, 4'd0};
            7'b0110000: return {1'b1, 4'd1};
            7'b1101101: return {1'b1, 4'd2};
            7'b1111001: return {1'b1, 4'd3};
            7'b0110011: return {1'b1, 4'd4};
            7'b1011011: return {1'b1, 4'd5};
            7'b1011111: return {1'b1, 4'd6};
            7'b1110000: return {1'b1, 4'd7};
            7'b1111111: return {1'b1, 4'd8};
            7'b1111011: return {1'b1, 4'd9};
            default:    return 5'd0;
        endcase
    endfunction

    function automatic logic [9:0] bcd_to_bin(input logic [11:0] b);
        return 10'(b[11:8]) * 10'd100 + 10'(b[7:4]) * 10'd10 + 10'(b[3:0]);
    endfunction

    function automatic logic [9:0] inc_mod1000(input logic [9:0] v);
        return (v == 10'd999) ? 10'd0 : v + 10'd1;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
        return (&c) ? c : c + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [6:0] w_seg0;
    logic [6:0] w_seg1;
    logic [6:0] w_seg2;

`ifdef SEG_ACTIVE_LOW_EN
    assign w_seg0 = ~i_seg0;
    assign w_seg1 = ~i_seg1;
    assign w_seg2 = ~i_seg2;
`else
    assign w_seg0 = i_seg0;
    assign w_seg1 = i_seg1;
    assign w_seg2 = i_seg2;
`endif

    // Input decode (combinational, feeds the single register stage)
    logic [4:0]  w_dec0;
    logic [4:0]  w_dec1;
    logic [4:0]  w_dec2;
    logic        w_legal;
    logic [11:0] w_bcd_new;
    logic [9:0]  w_value_new;
    logic        w_consistent;

    state_t                 r_state;
    logic [9:0]             r_prev;
    logic                   r_prev_valid;
    logic [3:0]             r_match_cnt;
    logic [11:0]            r_bcd;
    logic [9:0]             r_value;
    logic                   r_valid;
    logic                   r_glyph_err;
    logic                   r_seq_err;
    logic [ERR_CNT_W-1:0]   r_err_count;

    assign w_dec0       = decode_glyph(w_seg0);
    assign w_dec1       = decode_glyph(w_seg1);
    assign w_dec2       = decode_glyph(w_seg2);
    assign w_legal      = w_dec0[4] & w_dec1[4] & w_dec2[4];
    assign w_bcd_new    = {w_dec2[3:0], w_dec1[3:0], w_dec0[3:0]};
    assign w_value_new  = bcd_to_bin(w_bcd_new);
    assign w_consistent = (w_value_new == r_prev) || (w_value_new == inc_mod1000(r_prev));

    state_t               w_state_nxt;
    logic [9:0]           w_prev_nxt;
    logic                 w_prev_valid_nxt;
    logic [3:0]           w_match_cnt_nxt;
    logic [11:0]          w_bcd_nxt;
    logic [9:0]           w_value_nxt;
    logic                 w_valid_nxt;
    logic                 w_glyph_err_nxt;
    logic                 w_seq_err_nxt;
    logic [ERR_CNT_W-1:0] w_err_count_nxt;

    always_comb begin
        w_state_nxt      = r_state;
        w_prev_nxt       = r_prev;
        w_prev_valid_nxt = r_prev_valid;
        w_match_cnt_nxt  = r_match_cnt;
        w_bcd_nxt        = r_bcd;
        w_value_nxt      = r_value;
        w_valid_nxt      = r_valid;
        w_glyph_err_nxt  = 1'b0;
        w_seq_err_nxt    = 1'b0;
        w_err_count_nxt  = r_err_count;

        if (i_sample_en) begin
            if (!w_legal) begin
                // Glyph errors pre-empt any sequence check on the same sample.
                w_glyph_err_nxt  = 1'b1;
                w_err_count_nxt  = sat_inc(r_err_count);
                w_state_nxt      = ST_HUNT;
                w_match_cnt_nxt  = 4'd0;
                w_prev_valid_nxt = 1'b0;
            end else begin
                w_bcd_nxt   = w_bcd_new;
                w_value_nxt = w_value_new;
                w_valid_nxt = 1'b1;
                w_prev_nxt  = w_value_new;
                case (r_state)
                    ST_HUNT: begin
                        if (!r_prev_valid) begin
                            w_prev_valid_nxt = 1'b1;
                            w_match_cnt_nxt  = 4'd0;
                        end else if (w_consistent) begin
                            w_match_cnt_nxt = r_match_cnt + 4'd1;
                            if (w_match_cnt_nxt >= LOCK_CNT_L) begin
                                w_state_nxt = ST_LOCKED;
                            end
                        end else begin
                            w_match_cnt_nxt = 4'd0;
                        end
                    end
                    ST_LOCKED: begin
                        if (!w_consistent) begin
                            w_seq_err_nxt   = 1'b1;
                            w_err_count_nxt = sat_inc(r_err_count);
                            w_state_nxt     = ST_HUNT;
                            w_match_cnt_nxt = 4'd0;
                        end
                    end
                    default: w_state_nxt = ST_HUNT;
                endcase
            end
        end
    end

    // Output/state register stage (1 clk after the sampling edge)
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_prev_valid <= 1'b0;
            r_match_cnt  <= 4'd0;
            r_bcd        <= 12'd0;
            r_value      <= 10'd0;
            r_valid      <= 1'b0;
            r_glyph_err  <= 1'b0;
            r_seq_err    <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_prev_valid <= w_prev_valid_nxt;
            r_match_cnt  <= w_match_cnt_nxt;
            r_bcd        <= w_bcd_nxt;
            r_value      <= w_value_nxt;
            r_valid      <= w_valid_nxt;
            r_glyph_err  <= w_glyph_err_nxt;
            r_seq_err    <= w_seq_err_nxt;
            r_err_count  <= w_err_count_nxt;
        end
    end

    // Previous value is only meaningful while r_prev_valid is set.
    always_ff @(posedge i_clk) begin
        r_prev <= w_prev_nxt;
    end

    assign o_bcd       = r_bcd;
    assign o_value     = r_value;
    assign o_valid     = r_valid;
    assign o_locked    = (r_state == ST_LOCKED);
    assign o_glyph_err = r_glyph_err;
    assign o_seq_err   = r_seq_err;
    assign o_err_count = r_err_count;

endmodule

// File: tb/tb_seg_decode_monitor.sv
// Directed self-checking bench for seg_decode_monitor (LOCK_COUNT=2, ERR_CNT_W=8).
// Glyphs are inverted on the bus when SEG_ACTIVE_LOW_EN is defined.
module tb_seg_decode_monitor;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  seg0 = 7'd0;
    logic [6:0]  seg1 = 7'd0;
    logic [6:0]  seg2 = 7'd0;
    logic        sample_en = 1'b0;
    logic [11:0] bcd;
    logic [9:0]  value;
    logic        valid;
    logic        locked;
    logic        glyph_err;
    logic        seq_err;
    logic [7:0]  err_count;

    int n_chk = 0;
    int n_err = 0;

    seg_decode_monitor #(
        .LOCK_COUNT (2),
        .ERR_CNT_W  (8)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_seg0      (seg0),
        .i_seg1      (seg1),
        .i_seg2      (seg2),
        .i_sample_en (sample_en),
        .o_bcd       (bcd),
        .o_value     (value),
        .o_valid     (valid),
        .o_locked    (locked),
        .o_glyph_err (glyph_err),
        .o_seq_err   (seq_err),
        .o_err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            default: return 7'b1111011;
        endcase
    endfunction

    function automatic logic [6:0] phys(input logic [6:0] g);
`ifdef SEG_ACTIVE_LOW_EN
        return ~g;
`else
        return g;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_raw(input logic [6:0] g2, input logic [6:0] g1, input logic [6:0] g0);
        seg2 = phys(g2);
        seg1 = phys(g1);
        seg0 = phys(g0);
        sample_en = 1'b1;
        tick();
    endtask

    task automatic drive_val(input int v);
        drive_raw(glyph(v / 100), glyph((v / 10) % 10), glyph(v % 10));
    endtask

    task automatic idle();
        sample_en = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sample_en = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        // Test 1: reset with all-8 glyphs and sampling enabled
        reset_n = 1'b0;
        seg0 = phys(7'b1111111);
        seg1 = phys(7'b1111111);
        seg2 = phys(7'b1111111);
        sample_en = 1'b1;
        repeat (3) tick();
        chk("rst_bcd", 32'(bcd), 0);
        chk("rst_value", 32'(value), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_glyph_err", 32'(glyph_err), 0);
        chk("rst_seq_err", 32'(seq_err), 0);
        chk("rst_err_count", 32'(err_count), 0);
        reset_n = 1'b1;

        // Test 2: lock-up on 000,001,002 then hold
        drive_val(0);
        chk("lock_v0", 32'(value), 0);
        chk("lock_valid0", 32'(valid), 1);
        chk("lock_lk0", 32'(locked), 0);
        drive_val(1);
        chk("lock_v1", 32'(value), 1);
        chk("lock_lk1", 32'(locked), 0);
        drive_val(2);
        chk("lock_v2", 32'(value), 2);
        chk("lock_bcd2", 32'(bcd), 32'h002);
        chk("lock_lk2", 32'(locked), 1);
        seg0 = phys(glyph(5));
        seg1 = phys(glyph(5));
        seg2 = phys(glyph(5));
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("hold_value", 32'(value), 2);
            chk("hold_locked", 32'(locked), 1);
            chk("hold_seq_err", 32'(seq_err), 0);
        end

        // Test 3: 999 -> 000 wrap while locked
        do_reset();
        drive_val(995);
        drive_val(996);
        drive_val(997);
        chk("wrap_lk997", 32'(locked), 1);
        drive_val(998);
        chk("wrap_v998", 32'(value), 998);
        chk("wrap_se998", 32'(seq_err), 0);
        drive_val(999);
        chk("wrap_v999", 32'(value), 999);
        chk("wrap_bcd999", 32'(bcd), 32'h999);
        drive_val(0);
        chk("wrap_v0", 32'(value), 0);
        chk("wrap_bcd0", 32'(bcd), 32'h000);
        chk("wrap_se0", 32'(seq_err), 0);
        chk("wrap_lk0", 32'(locked), 1);
        drive_val(0);
        chk("wrap_hold_lk", 32'(locked), 1);
        chk("wrap_hold_ec", 32'(err_count), 0);

        // Test 4: jump while locked; an inconsistent sample in HUNT is silent
        do_reset();
        drive_val(100);
        drive_val(3);
        chk("hunt_jump_se", 32'(seq_err), 0);
        chk("hunt_jump_ec", 32'(err_count), 0);
        drive_val(4);
        chk("hunt_lk4", 32'(locked), 0);
        drive_val(5);
        chk("jump_lk5", 32'(locked), 1);
        drive_val(7);
        chk("jump_se", 32'(seq_err), 1);
        chk("jump_ec", 32'(err_count), 1);
        chk("jump_lk", 32'(locked), 0);
        chk("jump_v", 32'(value), 7);
        idle();
        chk("jump_se_pulse", 32'(seq_err), 0);
        chk("jump_ec_hold", 32'(err_count), 1);

        // Test 5: illegal glyph while locked, then illegal glyph plus jump
        do_reset();
        drive_val(40);
        drive_val(41);
        drive_val(42);
        chk("ill_lk42", 32'(locked), 1);
        drive_raw(glyph(0), glyph(4), 7'b0000000);
        chk("ill_ge", 32'(glyph_err), 1);
        chk("ill_se", 32'(seq_err), 0);
        chk("ill_v", 32'(value), 42);
        chk("ill_bcd", 32'(bcd), 32'h042);
        chk("ill_ec", 32'(err_count), 1);
        chk("ill_lk", 32'(locked), 0);
        chk("ill_valid", 32'(valid), 1);
        idle();
        chk("ill_ge_pulse", 32'(glyph_err), 0);
        drive_val(42);
        drive_val(43);
        drive_val(44);
        chk("ill2_lk44", 32'(locked), 1);
        drive_raw(glyph(9), glyph(9), 7'b1000000);
        chk("ill2_ge", 32'(glyph_err), 1);
        chk("ill2_se", 32'(seq_err), 0);
        chk("ill2_ec", 32'(err_count), 2);
        chk("ill2_v", 32'(value), 44);
        chk("ill2_lk", 32'(locked), 0);

        // Test 6: error counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive_raw(7'b0000000, 7'b0000000, 7'b0000000);
            if (i == 9) chk("sat_ec10", 32'(err_count), 10);
            if (i == 254) chk("sat_ec255", 32'(err_count), 255);
        end
        chk("sat_ec_final", 32'(err_count), 255);
        chk("sat_ge", 32'(glyph_err), 1);
        chk("sat_valid", 32'(valid), 0);
        idle();
        chk("sat_ec_hold", 32'(err_count), 255);
        chk("sat_ge_idle", 32'(glyph_err), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/seg_decode_monitor.md
Name: seg_decode_monitor

Overview:
- Read-back end of the three-digit BCD 7-segment display path.
- Samples three 7-segment buses (units, tens, hundreds) and decodes each glyph back to BCD.
- Produces the BCD value and a 0–999 binary value.
- Checks that the displayed sequence only holds or increments by 1 (mod 1000); flags illegal glyphs and sequence jumps. Used as an on-chip display checker and bench monitor.

Parameters:
- LOCK_COUNT, 2: consecutive consistent valid samples needed to enter LOCKED (range 1–15).
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous active-low reset
- seg0  in  7  units glyph, bit6=a … bit0=g, active-high
- seg1  in  7  tens glyph, same encoding
- seg2  in  7  hundreds glyph, same encoding
- sample_en  in  1  sample the seg buses on this edge; when low, all inputs are ignored
- bcd  out  12  {hundreds, tens, units} decoded digits
- value  out  10  binary equivalent, 100*h + 10*t + u
- valid  out  1  bcd/value hold a decoded sample
- locked  out  1  tracker is in LOCKED
- glyph_err  out  1  one-cycle pulse: illegal glyph sampled
- seq_err  out  1  one-cycle pulse: sequence jump while LOCKED
- err_count  out  ERR_CNT_W  saturating count of glyph_err plus seq_err events

Behaviour:
- Reset (reset_n=0 at a clk edge): bcd=0, value=0, valid=0, locked=0, glyph_err=0, seq_err=0, err_count=0. Internally: state=HUNT, match counter=0, prev_valid=0. Reset wins over every other event, including mid-lock.
- Glyph table (a..g):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Any other 7-bit code is illegal.
- Sampling happens only on edges with sample_en=1. All outputs are registered, so latency is 1 clk from the sampling edge.
- Sample is legal (all three glyphs in the table):
  - bcd and value update; valid goes to 1 and stays 1 until reset.
  - value is computed from the decoded digits in the same cycle; max 999, fits 10 bits.
- Sample is illegal (any glyph not in the table):
  - bcd, value and valid hold.
  - glyph_err pulses.
  - err_count increments.
  - state goes to HUNT; match counter and prev_valid clear.
- Consistency rule: new sample N is consistent with prev P when N==P or N==(P+1) mod 1000. The 999 -> 000 transition is legal.
- FSM, HUNT state:
  - First legal sample with prev_valid=0: store prev, set prev_valid=1, match counter stays 0.
  - Consistent legal sample: match counter increments.
  - Inconsistent legal sample: match counter=0, prev updates, no error is flagged.
  - When match counter reaches LOCK_COUNT: go to LOCKED; locked=1 on that same edge.
- FSM, LOCKED state:
  - Consistent legal sample: prev updates, stay in LOCKED.
  - Inconsistent legal sample: seq_err pulses, err_count increments, go to HUNT, match counter=0, prev=new sample, value shows the new sample.
- Simultaneous events: glyph_err takes priority over seq_err; at most one err_count increment per cycle.
- err_count saturates at 2^ERR_CNT_W−1 and never wraps.
- sample_en=0: state, outputs and counters hold; glyph_err and seq_err stay 0.

Optional Feature:
- SEG_ACTIVE_LOW_EN:
  - Defined: seg0/1/2 are inverted at the input before decoding, for common-anode displays (e.g. glyph 0 = 0000001). All other behaviour is unchanged.
  - Undefined: inputs are active-high as tabulated.

Test Plan:
1. Reset: reset_n=0 for 3 clks with seg buses=1111111 and sample_en=1 -> all outputs 0, locked=0, err_count=0.
2. Lock-up: LOCK_COUNT=2, sample 000, 001, 002 on consecutive edges, then sample_en=0 for 4 clks.
   - Required: value 0, 1, 2; valid=1 from the first sample; locked rises on the edge sampling 002.
   - Outputs hold while sample_en=0.
3. Wrap: while locked, sample 998, 999, 000 -> value 998, 999, 0; bcd=12'h000; seq_err never asserts; locked stays 1.
4. Jump: locked at 005, then sample 007 -> seq_err high for exactly 1 clk, err_count=1, locked=0, value=7.
5. Illegal glyph: locked at 042, then seg0=0000000 -> glyph_err 1-clk pulse, value stays 42, err_count increments, locked=0. In the same run, an illegal glyph combined with a jumped value -> only glyph_err, +1 count.
6. Saturation: ERR_CNT_W=8, 300 consecutive illegal samples -> err_count=255 and holds. Repeat with SEG_ACTIVE_LOW_EN defined using inverted patterns -> same results as tests 2–5.
